// File: rtl/helloworld_bist_ctrl.sv
// Self-test engine for the HelloWorld FSM: holds the DUT in reset, drives
// LFSR stimulus on x25/x24/x23, compacts z0..z5 into a 6-bit MISR and
// compares the final signature against a golden value.
module helloworld_bist_ctrl #(
    parameter int unsigned N_VECTORS   = 64,
    parameter int unsigned DUT_LATENCY = 1,
    parameter int unsigned RST_CYCLES  = 4,
    parameter logic [7:0]  LFSR_SEED   = 8'h01,
    parameter logic [5:0]  GOLDEN_SIG  = 6'h00
) (
    input  logic       bertaClock,
    input  logic       global_reset,
    input  logic       start,
    output logic       dut_reset,
    output logic       x25,
    output logic       x24,
    output logic       x23,
    input  logic [5:0] z_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] signature
);

    typedef enum logic [2:0] {S_IDLE, S_DUT_RST, S_RUN, S_CHECK, S_DONE} state_t;

    // Wide enough for N_VECTORS+DUT_LATENCY at the largest allowed values.
    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(N_VECTORS + DUT_LATENCY - 1);
    localparam logic [CNT_W-1:0] N_VEC    = CNT_W'(N_VECTORS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [5:0]       misr_q, misr_d;
    logic [2:0]       stim_q, stim_d;
    logic             dut_rst_q, dut_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             cap_en;

    // Capture window opens once the first response has crossed the DUT.
    generate
        if (DUT_LATENCY == 0) begin : g_cap_now
            assign cap_en = 1'b1;
        end else begin : g_cap_lat
            assign cap_en = (cnt_q >= CNT_W'(DUT_LATENCY));
        end
    endgenerate

    // MISR with feedback polynomial x^6+x+1.
    function automatic logic [5:0] misr_next(input logic [5:0] m, input logic [5:0] z);
        logic [5:0] n;
        n[0] = m[5] ^ z[0];
        n[1] = m[0] ^ m[5] ^ z[1];
        for (int i = 2; i < 6; i++) n[i] = m[i-1] ^ z[i];
        return n;
    endfunction

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_DUT_RST;
                    cnt_d   = '0;
                    lfsr_d  = LFSR_SEED;
                    misr_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            S_DUT_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (cnt_q < N_VEC)
                    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                if (cap_en)
                    misr_d = misr_next(misr_q, z_in);
                if (cnt_q == RUN_LAST) begin
                    state_d = S_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CHECK: begin
                pass_d  = (misr_q == GOLDEN_SIG);
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are decoded from next-state values so they can be registered
        // without lagging the state they describe.
        stim_d    = (state_d == S_RUN && cnt_d < N_VEC) ? lfsr_d[2:0] : 3'b000;
        dut_rst_d = (state_d == S_DUT_RST);
        busy_d    = (state_d == S_DUT_RST) || (state_d == S_RUN) || (state_d == S_CHECK);
        done_d    = (state_d == S_DONE);
    end

    // State and output registers; reset aborts any run in progress.
    always_ff @(posedge bertaClock) begin
        if (global_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            misr_q    <= '0;
            stim_q    <= '0;
            dut_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            misr_q    <= misr_d;
            stim_q    <= stim_d;
            dut_rst_q <= dut_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign dut_reset = dut_rst_q;
    assign x25       = stim_q[2];
    assign x24       = stim_q[1];
    assign x23       = stim_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_q;

endmodule

// File: tb/tb_helloworld_bist_ctrl.sv
// Directed bench for helloworld_bist_ctrl: default build (A) plus a
// single-vector, zero-latency build (B).
module tb_helloworld_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, start_a, dr_a, x25_a, x24_a, x23_a, busy_a, done_a, pass_a;
    logic [5:0] z_a, sig_a;
    logic       rst_b, start_b, dr_b, x25_b, x24_b, x23_b, busy_b, done_b, pass_b;
    logic [5:0] z_b, sig_b;

    helloworld_bist_ctrl #(
        .N_VECTORS(64), .DUT_LATENCY(1), .RST_CYCLES(4),
        .LFSR_SEED(8'h01), .GOLDEN_SIG(6'h00)
    ) u_a (
        .bertaClock(clk), .global_reset(rst_a), .start(start_a),
        .dut_reset(dr_a), .x25(x25_a), .x24(x24_a), .x23(x23_a),
        .z_in(z_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .signature(sig_a)
    );

    helloworld_bist_ctrl #(
        .N_VECTORS(1), .DUT_LATENCY(0), .RST_CYCLES(4),
        .LFSR_SEED(8'h01), .GOLDEN_SIG(6'h00)
    ) u_b (
        .bertaClock(clk), .global_reset(rst_b), .start(start_b),
        .dut_reset(dr_b), .x25(x25_b), .x24(x24_b), .x23(x23_b),
        .z_in(z_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .signature(sig_b)
    );

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic       rst;
        logic       start;
        logic       dr;
        logic       busy;
        logic       done;
        logic [2:0] x;
        logic [5:0] sig;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(logic r, logic s, logic d, logic b, logic dn,
                                logic [2:0] x, logic [5:0] sg);
        vec_t v;
        v.rst = r; v.start = s; v.dr = d; v.busy = b; v.done = dn; v.x = x; v.sig = sg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] mstep(input logic [5:0] m, input logic [5:0] z);
        logic [5:0] n;
        n = {m[4:0], 1'b0} ^ {4'b0, m[5], m[5]} ^ z;
        return n;
    endfunction

    function automatic logic [5:0] pat(input int k);
        return 6'((k * 7 + 3) ^ (k >> 2));
    endfunction

    // Start a run on A; z for edge k is driven just before that edge.
    task automatic run_a(input bit use_pat, input int restart_k, output logic [5:0] sig_out);
        z_a = '0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("start_done_drop", done_a, 0);
        chk("start_busy", busy_a, 1);
        chk("start_dut_reset", dr_a, 1);
        chk("start_pass_clear", pass_a, 0);
        for (int k = 1; k <= 70; k++) begin
            start_a = (k == restart_k);
            z_a = use_pat ? pat(k) : 6'h00;
            tick();
            if (k == 69) begin
                chk("run_done_early", done_a, 0);
                chk("run_busy_check", busy_a, 1);
            end
        end
        start_a = 1'b0; z_a = '0;
        chk("run_done", done_a, 1);
        chk("run_busy_end", busy_a, 0);
        sig_out = sig_a;
    endtask

    logic [5:0] exp_sig, s1, s2;

    initial begin
        rst_a = 1'b1; start_a = 1'b0; z_a = '0;
        rst_b = 1'b1; start_b = 1'b0; z_b = '0;

        // Reset, idle, start, DUT reset window, first five stimulus vectors.
        tbl[0]  = mk(1, 0, 0, 0, 0, 3'b000, 6'h00);
        tbl[1]  = mk(1, 0, 0, 0, 0, 3'b000, 6'h00);
        tbl[2]  = mk(1, 0, 0, 0, 0, 3'b000, 6'h00);
        tbl[3]  = mk(0, 0, 0, 0, 0, 3'b000, 6'h00);
        tbl[4]  = mk(0, 1, 1, 1, 0, 3'b000, 6'h00);
        tbl[5]  = mk(0, 0, 1, 1, 0, 3'b000, 6'h00);
        tbl[6]  = mk(0, 0, 1, 1, 0, 3'b000, 6'h00);
        tbl[7]  = mk(0, 0, 1, 1, 0, 3'b000, 6'h00);
        tbl[8]  = mk(0, 0, 0, 1, 0, 3'b001, 6'h00);
        tbl[9]  = mk(0, 0, 0, 1, 0, 3'b010, 6'h00);
        tbl[10] = mk(0, 0, 0, 1, 0, 3'b100, 6'h00);
        tbl[11] = mk(0, 0, 0, 1, 0, 3'b000, 6'h00);
        tbl[12] = mk(0, 0, 0, 1, 0, 3'b001, 6'h00);

        for (int i = 0; i < 13; i++) begin
            rst_a = tbl[i].rst; start_a = tbl[i].start;
            if (i == 3) rst_b = 1'b0;
            tick();
            chk($sformatf("tbl%0d_dut_reset", i), dr_a, tbl[i].dr);
            chk($sformatf("tbl%0d_busy", i), busy_a, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), done_a, tbl[i].done);
            chk($sformatf("tbl%0d_stim", i), {x25_a, x24_a, x23_a}, tbl[i].x);
            chk($sformatf("tbl%0d_sig", i), sig_a, tbl[i].sig);
            chk($sformatf("tbl%0d_pass", i), pass_a, 0);
        end
        start_a = 1'b0;

        // Finish the zero-response run: table ended at edge 8 after start.
        for (int k = 9; k <= 70; k++) begin
            tick();
            if (k == 68) begin
                chk("zero_last_run_stim", {x25_a, x24_a, x23_a}, 3'b000);
                chk("zero_last_run_busy", busy_a, 1);
                chk("zero_last_run_dr", dr_a, 0);
            end
            if (k == 69) chk("zero_done_early", done_a, 0);
        end
        chk("zero_done", done_a, 1);
        chk("zero_busy", busy_a, 0);
        chk("zero_pass", pass_a, 1);
        chk("zero_sig", sig_a, 6'h00);

        // Patterned runs: captures land on edges 6..69.
        exp_sig = 6'h00;
        for (int k = 6; k <= 69; k++) exp_sig = mstep(exp_sig, pat(k));

        run_a(1'b1, 20, s1);        // start during RUN must be ignored
        chk("pat1_sig", s1, exp_sig);
        chk("pat1_pass", pass_a, (exp_sig == 6'h00));
        run_a(1'b1, 0, s2);
        chk("pat2_sig_repeat", s2, s1);
        chk("pat2_sig_model", s2, exp_sig);

        // Abort mid-run.
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            z_a = pat(k);
            tick();
        end
        chk("pre_abort_busy", busy_a, 1);
        rst_a = 1'b1; tick();
        chk("abort_busy", busy_a, 0);
        chk("abort_dr", dr_a, 0);
        chk("abort_stim", {x25_a, x24_a, x23_a}, 3'b000);
        chk("abort_sig", sig_a, 6'h00);
        chk("abort_done", done_a, 0);
        chk("abort_pass", pass_a, 0);

        // Reset and start together: reset wins.
        start_a = 1'b1; tick();
        chk("rst_start_busy", busy_a, 0);
        chk("rst_start_dr", dr_a, 0);
        rst_a = 1'b0; start_a = 1'b0; z_a = '0; tick();
        chk("post_rst_idle_busy", busy_a, 0);
        chk("post_rst_idle_done", done_a, 0);

        // Build B: one vector, zero latency, single capture of 6'h01.
        start_b = 1'b1; tick(); start_b = 1'b0;
        chk("b_start_dr", dr_b, 1);
        for (int k = 1; k <= 6; k++) begin
            z_b = (k == 5) ? 6'h01 : 6'h00;
            tick();
            if (k == 4) begin
                chk("b_stim", {x25_b, x24_b, x23_b}, 3'b001);
                chk("b_run_dr", dr_b, 0);
            end
            if (k == 5) begin
                chk("b_sig_after_cap", sig_b, 6'h01);
                chk("b_done_early", done_b, 0);
            end
        end
        chk("b_done", done_b, 1);
        chk("b_busy", busy_b, 0);
        chk("b_pass", pass_b, 0);
        chk("b_sig", sig_b, 6'h01);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
